// File: rtl/ufl_pkg.sv
// Shared types and constants for the UART frame loader.
// Imported by the loader top and its bench.
package ufl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SLOT,
    LOAD,
    DATA,
    CHECK,
    DONE
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SLOT    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/ufl_if.sv
// Byte-in / SDRAM-WR1-out bundle of the frame loader.
// slave = loader side, master = uart/sdram side.
interface ufl_if;

  logic [7:0]  iRX_DATA;
  logic        iRX_VALID;
  logic        iWR_FULL;
  logic [15:0] oWR_DATA;
  logic        oWR;
  logic [22:0] oWR_ADDR;
  logic [22:0] oWR_MAX_ADDR;
  logic        oWR_LOAD;
  logic        oBUSY;
  logic        oDONE;
  logic [2:0]  oSLOT;
  logic [1:0]  oERR;
  logic        oOVF;

  modport slave (
    input  iRX_DATA, iRX_VALID, iWR_FULL,
    output oWR_DATA, oWR, oWR_ADDR,
    output oWR_MAX_ADDR, oWR_LOAD,
    output oBUSY, oDONE, oSLOT,
    output oERR, oOVF
  );

  modport master (
    output iRX_DATA, iRX_VALID, iWR_FULL,
    input  oWR_DATA, oWR, oWR_ADDR,
    input  oWR_MAX_ADDR, oWR_LOAD,
    input  oBUSY, oDONE, oSLOT,
    input  oERR, oOVF
  );

endinterface

// File: rtl/ufl_timeout_timer.sv
// Idle-cycle watchdog: counts cycles without a reload
// while enabled and flags the last permitted idle cycle.
module ufl_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic reload_i,
  output logic expire_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LIM = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Count idle cycles; any byte or leaving the packet restarts.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || reload_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIM) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = en_i && !reload_i && (cnt_q == LIM);

endmodule

// File: rtl/uart_frame_loader.sv
// Parses UART image packets and streams pixels into
// SDRAM write port 1 of the selected frame slot.
module uart_frame_loader
  import ufl_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS   = 307200,
  parameter int unsigned NUM_SLOTS      = 5,
  parameter logic [22:0] SLOT_STRIDE    = 23'h04B000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned LOAD_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input logic iCLK,
  input logic iRST,
  ufl_if.slave bus
);

  localparam int PCW = $clog2(FRAME_PIXELS + 1);
  localparam int LCW = $clog2(LOAD_CYCLES + 1);
  localparam logic [PCW-1:0] PLAST = PCW'(FRAME_PIXELS - 1);
  localparam logic [LCW-1:0] LLAST = LCW'(LOAD_CYCLES - 1);
  localparam logic [22:0] FRAME_W = 23'(FRAME_PIXELS);

  state_t         state_q, state_d;
  logic [LCW-1:0] lcnt_q, lcnt_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic [7:0]     csum_q, csum_d;
  logic [7:0]     skid_q, skid_d;
  logic           skv_q, skv_d;
  logic [2:0]     id_q, id_d;
  logic [22:0]    addr_q, addr_d;
  logic [22:0]    max_q, max_d;
  logic           wr_q, wr_d;
  logic [15:0]    wdat_q, wdat_d;
  logic [2:0]     slot_q, slot_d;
  logic [1:0]     err_q, err_d;
  logic           ovf_q, ovf_d;

  logic       rxv;
  logic [7:0] rxd;
  logic       in_pkt;
  logic       expire;
  logic       take_v;
  logic [7:0] take_b;

  assign rxv = bus.iRX_VALID;
  assign rxd = bus.iRX_DATA;

  assign in_pkt = (state_q == SLOT) || (state_q == LOAD) ||
                  (state_q == DATA) || (state_q == CHECK);

  // A parked skid byte is always consumed before a live one.
  assign take_v = ((state_q == DATA) || (state_q == CHECK)) &&
                  (skv_q || rxv);
  assign take_b = skv_q ? skid_q : rxd;

  ufl_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmr (
    .clk_i   (iCLK),
    .rst_i   (iRST),
    .en_i    (in_pkt),
    .reload_i(rxv),
    .expire_o(expire)
  );

  // Packet FSM next state plus datapath updates.
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    pcnt_d  = pcnt_q;
    csum_d  = csum_q;
    skid_d  = skid_q;
    skv_d   = skv_q;
    id_d    = id_q;
    addr_d  = addr_q;
    max_d   = max_q;
    wr_d    = 1'b0;
    wdat_d  = wdat_q;
    slot_d  = slot_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    if (take_v && skv_q) begin
      if (rxv) skid_d = rxd;
      else     skv_d  = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        skv_d = 1'b0;
        if (rxv && rxd == SYNC_BYTE) begin
          state_d = SLOT;
          ovf_d   = 1'b0;
        end
      end
      SLOT: begin
        skv_d = 1'b0;
        if (rxv) begin
          if (32'(rxd) < NUM_SLOTS) begin
            state_d = LOAD;
            id_d    = rxd[2:0];
            addr_d  = 23'(rxd) * SLOT_STRIDE;
            max_d   = addr_d + FRAME_W;
            lcnt_d  = '0;
          end else begin
            state_d = IDLE;
            err_d   = ERR_SLOT;
          end
        end else if (expire) begin
          state_d = IDLE;
          err_d   = ERR_TIMEOUT;
        end
      end
      LOAD: begin
        pcnt_d = '0;
        csum_d = '0;
        if (rxv && !skv_q) begin
          skid_d = rxd;
          skv_d  = 1'b1;
        end
        if (expire) begin
          state_d = IDLE;
          err_d   = ERR_TIMEOUT;
        end else if (lcnt_q == LLAST) begin
          state_d = DATA;
        end else begin
          lcnt_d = lcnt_q + LCW'(1);
        end
      end
      DATA: begin
        if (take_v) begin
          pcnt_d = pcnt_q + PCW'(1);
          csum_d = csum_q ^ take_b;
          wr_d   = !bus.iWR_FULL;
          wdat_d = {8'h00, take_b};
          if (bus.iWR_FULL) ovf_d = 1'b1;
          if (pcnt_q == PLAST) state_d = CHECK;
        end else if (expire) begin
          state_d = IDLE;
          err_d   = ERR_TIMEOUT;
        end
      end
      CHECK: begin
        if (take_v) begin
          if (take_b == csum_q) begin
            state_d = DONE;
          end else begin
            state_d = IDLE;
            err_d   = ERR_CSUM;
          end
        end else if (expire) begin
          state_d = IDLE;
          err_d   = ERR_TIMEOUT;
        end
      end
      DONE: begin
        skv_d   = 1'b0;
        slot_d  = id_q;
        err_d   = ERR_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      lcnt_q  <= '0;
      pcnt_q  <= '0;
      csum_q  <= '0;
      skid_q  <= '0;
      skv_q   <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      max_q   <= FRAME_W;
      wr_q    <= 1'b0;
      wdat_q  <= '0;
      slot_q  <= '0;
      err_q   <= ERR_NONE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      pcnt_q  <= pcnt_d;
      csum_q  <= csum_d;
      skid_q  <= skid_d;
      skv_q   <= skv_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      max_q   <= max_d;
      wr_q    <= wr_d;
      wdat_q  <= wdat_d;
      slot_q  <= slot_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.oWR          = wr_q;
  assign bus.oWR_DATA     = wdat_q;
  assign bus.oWR_ADDR     = addr_q;
  assign bus.oWR_MAX_ADDR = max_q;
  assign bus.oWR_LOAD     = (state_q == LOAD);
  assign bus.oBUSY        = (state_q != IDLE);
  assign bus.oDONE        = (state_q == DONE);
  assign bus.oSLOT        = slot_q;
  assign bus.oERR         = err_q;
  assign bus.oOVF         = ovf_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader with a
// 16-pixel frame and 1000-cycle timeout.
module tb_uart_frame_loader;

  logic clk;
  logic rst;

  ufl_if u_if ();

  uart_frame_loader #(
    .FRAME_PIXELS  (16),
    .LOAD_CYCLES   (4),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (u_if)
  );

  typedef struct {
    logic [15:0] d;
    logic [22:0] a;
  } wr_t;

  wr_t         exp_wr[$];
  int          exp_load[$];
  logic [22:0] exp_done[$];

  int n_cmp = 0;
  int n_bad = 0;
  int run   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations as the DUT presents outputs.
  always @(negedge clk) begin
    if (!rst) begin
      if (u_if.oWR && u_if.oWR_LOAD) begin
        n_bad++;
        $display("FAIL wr_and_load: both high");
      end
      if (u_if.oWR) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_wr", {16'h0, u_if.oWR_DATA}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_data", {16'h0, u_if.oWR_DATA}, {16'h0, e.d});
          check("wr_addr", {9'h0, u_if.oWR_ADDR}, {9'h0, e.a});
        end
      end
      if (u_if.oDONE) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [22:0] ea;
          ea = exp_done.pop_front();
          check("done_addr", {9'h0, u_if.oWR_ADDR}, {9'h0, ea});
        end
      end
      if (u_if.oWR_LOAD) begin
        run++;
      end else if (run != 0) begin
        if (exp_load.size() == 0) check("unexpected_load", run, 0);
        else check("load_len", run, exp_load.pop_front());
        run = 0;
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    @(negedge clk);
    u_if.iRX_DATA  = b;
    u_if.iRX_VALID = 1'b1;
    @(negedge clk);
    u_if.iRX_VALID = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Full packet; full_idx marks the pixel sent under backpressure.
  task automatic pkt(input logic [7:0]  sl,
                     input logic [22:0] addr,
                     input logic [7:0]  base,
                     input logic [7:0]  step,
                     input logic [7:0]  cs,
                     input bit          good,
                     input bit          skid,
                     input int          full_idx);
    logic [7:0] p;
    send(8'hA5, 1);
    exp_load.push_back(4);
    send(sl, skid ? 0 : 6);
    for (int i = 0; i < 16; i++) begin
      p = base + 8'(i) * step;
      if (i == full_idx) u_if.iWR_FULL = 1'b1;
      else exp_wr.push_back('{d: {8'h00, p}, a: addr});
      send(p, (skid && i == 0) ? 6 : 1);
      u_if.iWR_FULL = 1'b0;
    end
    if (good) exp_done.push_back(addr);
    send(cs, 5);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    u_if.iRX_DATA  = 8'h00;
    u_if.iRX_VALID = 1'b0;
    u_if.iWR_FULL  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr",   u_if.oWR, 0);
    check("rst_load", u_if.oWR_LOAD, 0);
    check("rst_busy", u_if.oBUSY, 0);
    check("rst_addr", u_if.oWR_ADDR, 0);
    check("rst_max",  u_if.oWR_MAX_ADDR, 32'h10);
    check("rst_err",  u_if.oERR, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good packet to slot 2, pixels 00..0F.
    pkt(8'h02, 23'h096000, 8'h00, 8'h01, 8'h00, 1, 0, -1);
    check("p1_slot", u_if.oSLOT, 2);
    check("p1_err",  u_if.oERR, 0);
    check("p1_busy", u_if.oBUSY, 0);
    check("p1_max",  u_if.oWR_MAX_ADDR, 32'h096010);

    // Out-of-range slot id.
    send(8'hA5, 1);
    send(8'h07, 4);
    check("bad_slot_err",  u_if.oERR, 1);
    check("bad_slot_busy", u_if.oBUSY, 0);

    // Checksum mismatch: sixteen 5A bytes XOR to 00.
    pkt(8'h01, 23'h04B000, 8'h5A, 8'h00, 8'h01, 0, 0, -1);
    check("csum_err",  u_if.oERR, 3);
    check("csum_slot", u_if.oSLOT, 2);

    // Timeout after five pixels.
    send(8'hA5, 1);
    exp_load.push_back(4);
    send(8'h00, 6);
    for (int i = 0; i < 5; i++) begin
      exp_wr.push_back('{d: 16'h0030 + 16'(i), a: 23'h0});
      send(8'h30 + 8'(i), 1);
    end
    repeat (1005) @(negedge clk);
    check("to_err",  u_if.oERR, 2);
    check("to_busy", u_if.oBUSY, 0);

    // Recovery packet to slot 0: 20..2F XOR to 00.
    pkt(8'h00, 23'h000000, 8'h20, 8'h01, 8'h00, 1, 0, -1);
    check("rec_slot", u_if.oSLOT, 0);
    check("rec_err",  u_if.oERR, 0);

    // Pixel 0 lands in LOAD and goes via the skid register.
    pkt(8'h03, 23'h0E1000, 8'h40, 8'h01, 8'h00, 1, 1, -1);
    check("skid_slot", u_if.oSLOT, 3);
    check("skid_err",  u_if.oERR, 0);

    // Pixel 3 dropped under backpressure; checksum still counts it.
    pkt(8'h04, 23'h12C000, 8'h60, 8'h01, 8'h00, 1, 0, 3);
    check("ovf_set",  u_if.oOVF, 1);
    check("ovf_slot", u_if.oSLOT, 4);

    send(8'hA5, 1);
    check("ovf_clr",  u_if.oOVF, 0);
    check("sync_busy", u_if.oBUSY, 1);
    exp_load.push_back(4);
    send(8'h01, 6);
    for (int i = 0; i < 3; i++) begin
      exp_wr.push_back('{d: 16'h0070 + 16'(i), a: 23'h04B000});
      send(8'h70 + 8'(i), 1);
    end

    // Reset mid-DATA takes effect without a clock edge.
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", u_if.oBUSY, 0);
    check("mid_rst_wr",   u_if.oWR, 0);
    check("mid_rst_load", u_if.oWR_LOAD, 0);
    check("mid_rst_addr", u_if.oWR_ADDR, 0);
    check("mid_rst_max",  u_if.oWR_MAX_ADDR, 32'h10);
    check("mid_rst_slot", u_if.oSLOT, 0);
    check("mid_rst_err",  u_if.oERR, 0);
    check("mid_rst_ovf",  u_if.oOVF, 0);
    check("mid_rst_data", u_if.oWR_DATA, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("left_wr",   exp_wr.size(), 0);
    check("left_load", exp_load.size(), 0);
    check("left_done", exp_done.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
